// File: rtl/mix_pkg.sv
// Shared constants, types and FSM encoding for the mix_chk frame checker.
package mix_pkg;

  localparam int unsigned NWORDS  = 8;
  localparam int unsigned NSTAGES = 8;

  typedef logic [31:0] word_t;
  typedef word_t [NWORDS-1:0] ostate_t;

  localparam word_t A7 [NWORDS] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam word_t B7 [NWORDS] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  localparam word_t A8 [NWORDS] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
  localparam word_t B8 [NWORDS] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

  typedef enum logic [1:0] {
    COMPUTE,
    COLLECT,
    REPORT
  } fsm_t;

endpackage

// File: rtl/mix_chk_step.sv
// mix_step: one round step (stage, idx) of the mixing function; purely combinational,
// so a stimulus generator can reuse it to produce matching frames.
module mix_step
  import mix_pkg::*;
(
  input  logic [2:0] stage,
  input  logic [2:0] idx,
  input  ostate_t    o,
  output word_t      o_new
);

  logic [2:0] im1, im2, ip1, ip2, ip3, ip4, ip5;
  word_t cur;

  always_comb begin
    // 3-bit index arithmetic gives the mod-8 neighbour wrap for free
    im1 = idx - 3'd1;
    im2 = idx - 3'd2;
    ip1 = idx + 3'd1;
    ip2 = idx + 3'd2;
    ip3 = idx + 3'd3;
    ip4 = idx + 3'd4;
    ip5 = idx + 3'd5;
    cur = o[idx];
    o_new = cur;
    case (stage)
      3'd0: o_new = cur + {29'd0, idx};
      3'd1: o_new = cur + o[im1];
      3'd2: o_new = cur + o[ip1] - o[ip5];
      3'd3: o_new = cur ^ (o[ip3] << 16);
      3'd4: o_new = cur - (o[ip2] >> 17) + (o[ip4] >> 12);
      3'd5: o_new = cur + o[im1] - o[im2];
      3'd6: o_new = cur * A7[idx] + B7[idx];
      3'd7: o_new = cur * A8[idx] + B8[idx];
      default: o_new = cur;
    endcase
  end

endmodule

// File: rtl/mix_chk.sv
// mix_chk: advances an 8-word model state one round per frame, then checks 8 received words.
// Optional MIX_CHK_RESYNC_EN: a failing frame's received words become the next round's base.
module mix_chk
  import mix_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             chk_done,
  output logic             chk_pass,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  fsm_t       state, state_nx;
  logic [5:0] step;
  logic [2:0] word_idx;
  logic       frame_err;
  logic       accept;
  logic       mism;
  ostate_t    o;
  word_t      o_new;
`ifdef MIX_CHK_RESYNC_EN
  ostate_t    cap;
`endif

  mix_step u_step (
    .stage (step[5:3]),
    .idx   (step[2:0]),
    .o     (o),
    .o_new (o_new)
  );

  assign in_ready = (state == COLLECT);
  assign chk_done = (state == REPORT);
  assign accept   = in_ready && in_valid;
  assign mism     = (in_data != o[word_idx]);

  always_comb begin
    state_nx = state;
    case (state)
      COMPUTE: if (step == 6'd63) state_nx = COLLECT;
      COLLECT: if (accept && word_idx == 3'd7) state_nx = REPORT;
      REPORT:  state_nx = COMPUTE;
      default: state_nx = COMPUTE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COMPUTE;
      step        <= '0;
      word_idx    <= '0;
      frame_err   <= 1'b0;
      chk_pass    <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
      for (int unsigned i = 0; i < NWORDS; i++) o[i] <= word_t'(i);
`ifdef MIX_CHK_RESYNC_EN
      cap <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        COMPUTE: begin
          o[step[2:0]] <= o_new;
          step         <= step + 6'd1;
        end
        COLLECT: begin
          if (accept) begin
            word_idx  <= word_idx + 3'd1;
            frame_err <= frame_err | mism;
`ifdef MIX_CHK_RESYNC_EN
            cap[word_idx] <= in_data;
`endif
            // verdict registered with the last beat so it is valid alongside chk_done
            if (word_idx == 3'd7) chk_pass <= !(frame_err | mism);
          end
        end
        REPORT: begin
          if (frame_count != '1) frame_count <= frame_count + 1'b1;
          if (frame_err && err_count != '1) err_count <= err_count + 1'b1;
          frame_err <= 1'b0;
`ifdef MIX_CHK_RESYNC_EN
          if (frame_err) o <= cap;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mix_chk.md
MIX_CHK -- requirements
Module: mix_chk

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of frame_count and err_count.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  producer has a state word on in_data.
REQ-005 in_ready  output  1  checker accepts a word this cycle.
REQ-006 in_data  input  32  state word; 8 beats per frame, word o0 first, o7 last.
REQ-007 chk_done  output  1  one-cycle pulse when a frame verdict is ready.
REQ-008 chk_pass  output  1  verdict of the last frame (1 = all 8 words matched); held until the next chk_done.
REQ-009 frame_count  output  CNT_W  frames checked, saturating.
REQ-010 err_count  output  CNT_W  frames with at least one mismatch, saturating.

Function
REQ-011 The block SHALL hold a model state o[0..7] (32-bit each) and SHALL apply one round per frame, as 8 stages in order; within each stage i = 0..7 in order, indices mod 8, each step seeing all earlier updates:
- S1 o[i] += i
- S2 o[i] += o[i-1]
- S3 o[i] = o[i] + o[i+1] - o[i+5]
- S4 o[i] ^= o[i+3] << 16
- S5 o[i] = o[i] - (o[i+2] >> 17) + (o[i+4] >> 12), logical shifts
- S6 o[i] = o[i] + o[i-1] - o[i-2]
- S7 o[i] = o[i]*A7[i] + B7[i]; A7 = {2,3,5,7,11,13,17,19}; B7 = {3,5,7,11,13,17,19,23}
- S8 o[i] = o[i]*A8[i] + B8[i]; A8 = {2,3,3,3,5,13,35,87}; B8 = {0,1,8,27,64,125,216,343}
REQ-012 All arithmetic SHALL be unsigned modulo 2^32; results truncated to 32 bits.
REQ-013 The FSM SHALL have states COMPUTE, COLLECT and REPORT.
REQ-014 COMPUTE SHALL execute exactly one step (stage, i) per cycle on a single shared datapath: 64 cycles, in_ready=0, then go to COLLECT.
REQ-015 COLLECT SHALL drive in_ready=1 and compare each accepted word (in_valid&&in_ready) against o[word_idx].
REQ-016 Any mismatch SHALL set a sticky frame-error flag; after the 8th accepted word the FSM SHALL go to REPORT.
REQ-017 REPORT SHALL last 1 cycle: chk_done=1, chk_pass=!error, frame_count+1, err_count+1 on error, clear the flag, then go to COMPUTE.
REQ-018 Counters SHALL saturate at all-ones and never wrap.
REQ-019 Idle in_valid in COLLECT SHALL stall without timeout; word_idx advances only on an accepted beat.
REQ-020 End-to-end timing: the first in_ready is 64 cycles after reset release; chk_done is 1 cycle after the 8th beat; the next in_ready is 65 cycles after chk_done.

Reset
REQ-021 Reset SHALL set o[i]=i, FSM=COMPUTE, step=0, word_idx=0, error flag=0, chk_done=0, chk_pass=0, frame_count=0, err_count=0, in_ready=0.
REQ-022 Assertion mid-frame or mid-COMPUTE SHALL discard the partial frame and partial round, with no count update.

Configuration
REQ-023 With MIX_CHK_RESYNC_EN defined, the block SHALL capture the 8 received words; on a failing REPORT it SHALL load them into o[] as the base for the next round.
REQ-024 Without MIX_CHK_RESYNC_EN, the capture storage SHALL be absent and o[] SHALL advance only through its own rounds, regardless of mismatches.

Structure
REQ-025 Package mix_pkg SHALL hold NWORDS=8, NSTAGES=8, the A7/B7/A8/B8 constant arrays and the FSM state enum.
REQ-026 Sub-module mix_step SHALL be combinational: (stage, i, o[0..7]) -> new o[i]; it is reusable by a matching generator.

Verification
REQ-027 Reset, then a generator stream from the same round definition, 3 frames -> 3 chk_done pulses, chk_pass=1 each, frame_count=3, err_count=0.
REQ-028 Frame 2 word 5 XOR 32'h1 -> frame-2 chk_pass=0, err_count=1; without RESYNC, frame 3 correct -> chk_pass=1.
REQ-029 RESYNC build, same corruption, frame 3 generated from the corrupted frame 2 -> chk_pass=1; frame 3 from the true state -> chk_pass=0.
REQ-030 Random in_valid gaps (50% duty) -> verdicts identical to the gapless run; in_ready=0 for exactly 64 cycles after each chk_done+1.
REQ-031 rst_n low after beat 4 of frame 1 -> counters 0, in_ready=0; the restarted correct stream passes from o[i]=i.
REQ-032 CNT_W=2 with 5 bad frames -> err_count=3, frame_count=3.
